// File: rtl/div.sv
// div: sequential 16-by-8 unsigned restoring divider, one quotient bit per clock.
// Latency: 16 busy cycles for a nonzero divisor and 1 cycle for a zero divisor. Results are loaded on the edge where busy_o falls.
// Backpressure: start_i is accepted only while busy_o=0 and is ignored otherwise. Results hold until the next operation completes.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-high reset; aborts any operation in flight
//   a_bi     dividend [15:0], sampled when a start is accepted
//   b_bi     divisor  [7:0],  sampled when a start is accepted
//   start_i  operation request
//   busy_o   high while an operation is in progress (decoded from state)
//   q_bo     registered quotient [15:0]
//   r_bo     registered remainder [7:0]
//   dbz_o    registered divide-by-zero flag of the last completed operation
module div (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] a_bi,
  input  logic [7:0]  b_bi,
  input  logic        start_i,
  output logic        busy_o,
  output logic [15:0] q_bo,
  output logic [7:0]  r_bo,
  output logic        dbz_o
);

  typedef enum logic {IDLE, WORK} state_t;

  state_t      state_q, state_d;
  logic [15:0] dvd_q, dvd_d;    // dividend shift register, MSB consumed each step
  logic [7:0]  dvs_q, dvs_d;    // latched divisor
  logic [7:0]  rem_q, rem_d;    // partial remainder
  logic [15:0] quo_q, quo_d;    // quotient shift register
  logic [3:0]  cnt_q, cnt_d;    // steps remaining minus one
  logic        zdiv_q, zdiv_d;  // latched divisor was zero
  logic [15:0] q_q, q_d;
  logic [7:0]  r_q, r_d;
  logic        dbz_q, dbz_d;

  // One restoring step. The partial remainder is always below the divisor,
  // so it fits in 8 bits between steps. Only the trial value t needs a
  // ninth bit for the compare. When t >= divisor, the difference is below
  // the divisor, so an 8-bit subtract of the low bits is exact.
  logic [8:0]  t;
  logic        ge;
  logic [7:0]  diff;
  logic [7:0]  rem_nxt;
  logic [15:0] quo_nxt;

  always_comb begin
    t       = {rem_q, dvd_q[15]};
    ge      = (t >= {1'b0, dvs_q});
    diff    = t[7:0] - dvs_q;
    rem_nxt = ge ? diff : t[7:0];
    quo_nxt = {quo_q[14:0], ge};
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    zdiv_d  = zdiv_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          dvd_d   = a_bi;
          dvs_d   = b_bi;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = 4'd15;
          zdiv_d  = (b_bi == 8'd0);
          state_d = WORK;
        end
      end
      WORK: begin
        if (zdiv_q) begin
          // Zero divisor: no iterations. Report all-ones and the low dividend byte.
          q_d     = 16'hFFFF;
          r_d     = dvd_q[7:0];
          dbz_d   = 1'b1;
          state_d = IDLE;
        end else begin
          rem_d = rem_nxt;
          quo_d = quo_nxt;
          dvd_d = {dvd_q[14:0], 1'b0};
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd0) begin
            q_d     = quo_nxt;
            r_d     = rem_nxt;
            dbz_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      zdiv_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      zdiv_q  <= zdiv_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy_o = (state_q == WORK);
  assign q_bo   = q_q;
  assign r_bo   = r_q;
  assign dbz_o  = dbz_q;

endmodule

// File: tb/tb_div.sv
// tb_div: directed checks of the sequential divider using hand-computed expected values.
// Inputs are driven on the falling edge and outputs are sampled on the falling edge.
// Every busy wait is bounded. An expired bound counts as a failed check.
module tb_div;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] a_bi = '0;
  logic [7:0]  b_bi = '0;
  logic        start_i = 1'b0;
  logic        busy_o;
  logic [15:0] q_bo;
  logic [7:0]  r_bo;
  logic        dbz_o;

  int n_chk = 0;
  int n_err = 0;

  div dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .a_bi   (a_bi),
    .b_bi   (b_bi),
    .start_i(start_i),
    .busy_o (busy_o),
    .q_bo   (q_bo),
    .r_bo   (r_bo),
    .dbz_o  (dbz_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle. On return we are at the negedge after the accepting edge.
  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk_i);
    a_bi    = a;
    b_bi    = b;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    a_bi    = 16'hDEAD;
    b_bi    = 8'h00;
  endtask

  // Count busy cycles until busy_o falls. At busy cycle inj_at, raise a
  // stray start (a=50, b=5). At busy cycle rst_at, assert reset and return.
  // A value of 0 disables the corresponding injection.
  task automatic wait_done(output int cycles, input int inj_at, input int rst_at);
    int cnt;
    cnt = 0;
    while (busy_o === 1'b1 && cnt < 40) begin
      cnt++;
      start_i = 1'b0;
      if (cnt == inj_at) begin
        a_bi    = 16'd50;
        b_bi    = 8'd5;
        start_i = 1'b1;
      end
      if (cnt == rst_at) begin
        rst_i  = 1'b1;
        cycles = cnt;
        return;
      end
      @(negedge clk_i);
    end
    start_i = 1'b0;
    if (cnt >= 40) chk("busy_timeout", {31'd0, busy_o}, 32'd0);
    cycles = cnt;
  endtask

  task automatic run(input string tag, input logic [15:0] a, input logic [7:0] b,
                     input int exp_cyc, input logic [15:0] eq, input logic [7:0] er,
                     input logic edbz);
    int cyc;
    start_op(a, b);
    wait_done(cyc, 0, 0);
    chk({tag, "_cyc"}, cyc, exp_cyc);
    chk({tag, "_q"}, {16'd0, q_bo}, {16'd0, eq});
    chk({tag, "_r"}, {24'd0, r_bo}, {24'd0, er});
    chk({tag, "_dbz"}, {31'd0, dbz_o}, {31'd0, edbz});
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_q", {16'd0, q_bo}, 32'd0);
    chk("rst_r", {24'd0, r_bo}, 32'd0);
    chk("rst_dbz", {31'd0, dbz_o}, 32'd0);
    rst_i = 1'b0;

    run("d1000_7", 16'd1000, 8'd7, 16, 16'd142, 8'd6, 1'b0);
    run("dffff_ff", 16'hFFFF, 8'hFF, 16, 16'h0101, 8'd0, 1'b0);
    run("dffff_1", 16'hFFFF, 8'd1, 16, 16'hFFFF, 8'd0, 1'b0);
    run("d5_9", 16'd5, 8'd9, 16, 16'd0, 8'd5, 1'b0);
    run("d0_3", 16'd0, 8'd3, 16, 16'd0, 8'd0, 1'b0);
    run("dbz", 16'h1234, 8'd0, 1, 16'hFFFF, 8'h34, 1'b1);
    run("d100_10", 16'd100, 8'd10, 16, 16'd10, 8'd0, 1'b0);

    // A start during busy is ignored. Old results hold until completion.
    start_op(16'd1000, 8'd7);
    chk("hold_q_busy", {16'd0, q_bo}, 32'd10);
    wait_done(cyc, 5, 0);
    chk("ign_cyc", cyc, 16);
    chk("ign_q", {16'd0, q_bo}, 32'd142);
    chk("ign_r", {24'd0, r_bo}, 32'd6);
    // The stray start must not have launched a second operation.
    @(negedge clk_i);
    chk("ign_idle", {31'd0, busy_o}, 32'd0);

    // Reset during an operation aborts it and clears the outputs.
    run("d200_3", 16'd200, 8'd3, 16, 16'd66, 8'd2, 1'b0);
    start_op(16'd999, 8'd4);
    wait_done(cyc, 0, 8);
    #1;
    chk("mrst_busy", {31'd0, busy_o}, 32'd0);
    chk("mrst_q", {16'd0, q_bo}, 32'd0);
    chk("mrst_r", {24'd0, r_bo}, 32'd0);
    chk("mrst_dbz", {31'd0, dbz_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    run("d999_4", 16'd999, 8'd4, 16, 16'd249, 8'd3, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
